fetch_stage: RTL and testbench

LC-3b instruction-fetch stage. Sits directly upstream of the IF/ID pipeline register and drives that register's load, PC input and instruction input. It owns the PC, runs the read/resp handshake with the instruction memory port, and holds an instruction captured while ID is stalled. It also applies taken-branch/jump redirects from later stages and inserts NOP bubbles on a flush.

---
 rtl/fetch_stage.sv | 158 +++++++++++++++
 tb/tb_fetch_stage.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// LC-3b instruction-fetch stage.
// Owns the PC, runs the read/resp handshake with instruction memory, parks an
// instruction fetched while ID is stalled, applies redirects from later stages
// and feeds bubbles into IF/ID while a redirect is being resolved.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   stall               ID/hazard unit: hold IF/ID this cycle
//   redirect            later stage: change the fetch stream this cycle
//   redirect_pc         redirect target (bit 0 ignored)
//   I_resp, I_rdata     instruction memory response / data
//   I_read, I_addr      instruction memory request / address
//   if_id_load          IF/ID load enable
//   PC_out              IF/ID PC input (fetched address + 2)
//   inst_out            IF/ID instruction input
//   inst_valid          inst_out is a real instruction, not a bubble
//
// state | meaning
// ------+-----------------------------------------------------------
// FETCH | read request at pc outstanding; deliver on I_resp
// HOLD  | instruction parked in hold_inst/hold_pc while ID is stalled
// DRAIN | redirect seen mid-read; wait for the stale read, then jump to tgt
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INST = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        I_resp,
    input  logic [15:0] I_rdata,
    output logic        I_read,
    output logic [15:0] I_addr,
    output logic        if_id_load,
    output logic [15:0] PC_out,
    output logic [15:0] inst_out,
    output logic        inst_valid
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [15:0] RESET_PC_AL = {RESET_PC[15:1], 1'b0};

    state_t      state, state_nxt;
    logic [15:0] pc, pc_nxt;
    logic [15:0] hold_inst, hold_inst_nxt;
    logic [15:0] hold_pc, hold_pc_nxt;
    logic [15:0] tgt, tgt_nxt;

    logic [15:0] pc_inc;
    logic [15:0] rpc;

    logic        read_raw;
    logic        load_raw;
    logic [15:0] pc_out_raw;
    logic [15:0] inst_raw;
    logic        valid_raw;

    assign pc_inc = pc + 16'd2;
    assign rpc    = {redirect_pc[15:1], 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH;
            pc        <= RESET_PC_AL;
            hold_inst <= 16'h0000;
            hold_pc   <= 16'h0000;
            tgt       <= 16'h0000;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            hold_inst <= hold_inst_nxt;
            hold_pc   <= hold_pc_nxt;
            tgt       <= tgt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        hold_inst_nxt = hold_inst;
        hold_pc_nxt   = hold_pc;
        tgt_nxt       = tgt;
        read_raw      = 1'b1;
        load_raw      = redirect | ~stall;
        pc_out_raw    = pc;
        inst_raw      = NOP_INST;
        valid_raw     = 1'b0;

        case (state)
            FETCH: begin
                if (redirect) begin
                    if (I_resp) begin
                        pc_nxt = rpc;
                    end else begin
                        // read already on the bus must finish before jumping
                        tgt_nxt   = rpc;
                        state_nxt = DRAIN;
                    end
                end else if (I_resp) begin
                    pc_nxt = pc_inc;
                    if (stall) begin
                        hold_inst_nxt = I_rdata;
                        hold_pc_nxt   = pc_inc;
                        state_nxt     = HOLD;
                    end else begin
                        inst_raw   = I_rdata;
                        pc_out_raw = pc_inc;
                        valid_raw  = 1'b1;
                    end
                end
            end

            HOLD: begin
                read_raw = 1'b0;
                if (redirect) begin
                    pc_nxt    = rpc;
                    state_nxt = FETCH;
                end else begin
                    inst_raw   = hold_inst;
                    pc_out_raw = hold_pc;
                    valid_raw  = 1'b1;
                    if (!stall) begin
                        state_nxt = FETCH;
                    end
                end
            end

            DRAIN: begin
                if (I_resp) begin
                    pc_nxt    = redirect ? rpc : tgt;
                    state_nxt = FETCH;
                end else if (redirect) begin
                    tgt_nxt = rpc;
                end
            end

            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    // Everything is forced quiet while reset is held.
    assign I_read     = rst_n & read_raw;
    assign I_addr     = rst_n ? pc : 16'h0000;
    assign if_id_load = rst_n & load_raw;
    assign PC_out     = rst_n ? pc_out_raw : 16'h0000;
    assign inst_out   = rst_n ? inst_raw : 16'h0000;
    assign inst_valid = rst_n & valid_raw;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [15:0] NOP = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        I_resp;
    logic [15:0] I_rdata;
    logic        I_read;
    logic [15:0] I_addr;
    logic        if_id_load;
    logic [15:0] PC_out;
    logic [15:0] inst_out;
    logic        inst_valid;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(16'h0000), .NOP_INST(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .I_resp(I_resp), .I_rdata(I_rdata),
        .I_read(I_read), .I_addr(I_addr), .if_id_load(if_id_load),
        .PC_out(PC_out), .inst_out(inst_out), .inst_valid(inst_valid)
    );

    wire [50:0] got_v = {I_read, I_addr, if_id_load, PC_out, inst_out, inst_valid};
    logic [50:0] exp_v;

    // Reference model: the fetch pointer, an optional parked instruction and
    // an optional pending jump target (kept as queues of 0 or 1 entries).
    logic [15:0] m_pc;
    logic [31:0] m_parked[$];   // {inst, pc_out}
    logic [15:0] m_jump[$];     // target waiting for a stale read

    function automatic logic [15:0] even(input logic [15:0] a);
        return a & 16'hFFFE;
    endfunction

    task automatic model_reset();
        m_pc = 16'h0000;
        m_parked.delete();
        m_jump.delete();
    endtask

    task automatic model_eval();
        logic        e_read, e_valid, e_load;
        logic [15:0] e_pco, e_inst;
        if (!rst_n) begin
            exp_v = '0;
            return;
        end
        e_read  = (m_parked.size() == 0);
        e_load  = redirect | ~stall;
        e_pco   = m_pc;
        e_inst  = NOP;
        e_valid = 1'b0;
        if (!redirect) begin
            if (m_parked.size() != 0) begin
                e_inst  = m_parked[0][31:16];
                e_pco   = m_parked[0][15:0];
                e_valid = 1'b1;
            end else if (m_jump.size() == 0 && I_resp && !stall) begin
                e_inst  = I_rdata;
                e_pco   = m_pc + 16'd2;
                e_valid = 1'b1;
            end
        end
        exp_v = {e_read, m_pc, e_load, e_pco, e_inst, e_valid};
    endtask

    task automatic model_advance();
        if (m_parked.size() != 0) begin
            if (redirect) begin
                m_parked.delete();
                m_pc = even(redirect_pc);
            end else if (!stall) begin
                m_parked.delete();
            end
        end else if (m_jump.size() != 0) begin
            if (redirect) m_jump[0] = even(redirect_pc);
            if (I_resp) begin
                m_pc = m_jump.pop_front();
            end
        end else if (redirect) begin
            if (I_resp) m_pc = even(redirect_pc);
            else        m_jump.push_back(even(redirect_pc));
        end else if (I_resp) begin
            m_pc = m_pc + 16'd2;
            if (stall) m_parked.push_back({I_rdata, m_pc});
        end
    endtask

    // Called just after a falling edge: drive inputs, let them settle, predict.
    task automatic apply(input logic s, input logic r, input logic [15:0] rpc,
                         input logic resp, input logic [15:0] data);
        stall = s; redirect = r; redirect_pc = rpc; I_resp = resp; I_rdata = data;
        #1;
        model_eval();
    endtask

    task automatic tick();
        model_advance();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        apply(0, 0, 16'h0, 1, 16'h1234);
        @(posedge clk);
        #1;
        vectors++;
        if (got_v !== 51'd0) begin
            miscompares++;
            $display("FAIL reset outputs got=%h exp=0", got_v);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 16'h0, 1, 16'h1234);
            vectors++;
            if (got_v !== exp_v) begin
                miscompares++;
                $display("FAIL stream%0d got=%h exp=%h", i, got_v, exp_v);
            end
            vectors++;
            if ({I_addr, PC_out, inst_valid, if_id_load} !== {16'(2*i), 16'(2*i+2), 2'b11}) begin
                miscompares++;
                $display("FAIL stream_const%0d addr=%h pc_out=%h v=%b ld=%b exp addr=%h pc_out=%h",
                         i, I_addr, PC_out, inst_valid, if_id_load, 16'(2*i), 16'(2*i+2));
            end
            tick();
        end
    endtask

    task automatic test_wait();
        apply(0, 1, 16'h0010, 1, 16'h5555);
        tick();
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 16'h0, (i == 2), 16'h7777);
            vectors++;
            if (got_v !== exp_v) begin
                miscompares++;
                $display("FAIL wait%0d got=%h exp=%h", i, got_v, exp_v);
            end
            vectors++;
            if (i < 2 && {I_read, I_addr, inst_out, inst_valid} !== {1'b1, 16'h0010, NOP, 1'b0}) begin
                miscompares++;
                $display("FAIL wait_bubble%0d rd=%b addr=%h inst=%h v=%b", i, I_read, I_addr, inst_out, inst_valid);
            end else if (i == 2 && {PC_out, inst_out, inst_valid} !== {16'h0012, 16'h7777, 1'b1}) begin
                miscompares++;
                $display("FAIL wait_deliver pc_out=%h inst=%h v=%b exp 0012 7777 1", PC_out, inst_out, inst_valid);
            end
            tick();
        end
    endtask

    task automatic test_stall();
        apply(0, 1, 16'h0020, 1, 16'h0);
        tick();
        apply(1, 0, 16'h0, 1, 16'hABCD);
        vectors++;
        if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL stall_resp got=%h exp=%h", got_v, exp_v);
        end
        tick();
        apply(1, 0, 16'h0, 1, 16'h9999);
        vectors++;
        if ({I_read, if_id_load} !== 2'b00 || got_v !== exp_v) begin
            miscompares++;
            $display("FAIL stall_hold rd=%b ld=%b got=%h exp=%h", I_read, if_id_load, got_v, exp_v);
        end
        tick();
        apply(0, 0, 16'h0, 1, 16'h9999);
        vectors++;
        if ({if_id_load, inst_out, PC_out, inst_valid} !== {1'b1, 16'hABCD, 16'h0022, 1'b1}) begin
            miscompares++;
            $display("FAIL stall_release inst=%h pc_out=%h v=%b ld=%b exp ABCD 0022", inst_out, PC_out, inst_valid, if_id_load);
        end
        tick();
        apply(0, 0, 16'h0, 1, 16'h4242);
        vectors++;
        if (I_addr !== 16'h0022 || got_v !== exp_v) begin
            miscompares++;
            $display("FAIL stall_resume addr=%h exp 0022 got=%h exp=%h", I_addr, got_v, exp_v);
        end
        tick();
    endtask

    task automatic test_redirect_drain();
        apply(0, 1, 16'h0030, 1, 16'h0);
        tick();
        apply(0, 1, 16'h4000, 0, 16'h0);
        apply(0, 1, 16'h4000, 0, 16'h0);
        vectors++;
        if (got_v !== exp_v || inst_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL redir_issue got=%h exp=%h", got_v, exp_v);
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            apply(0, 0, 16'h0, (i == 1), 16'hDEAD);
            vectors++;
            if ({I_read, I_addr, inst_valid, if_id_load} !== {1'b1, 16'h0030, 1'b0, 1'b1} || got_v !== exp_v) begin
                miscompares++;
                $display("FAIL redir_drain%0d rd=%b addr=%h v=%b got=%h exp=%h", i, I_read, I_addr, inst_valid, got_v, exp_v);
            end
            tick();
        end
        apply(0, 0, 16'h0, 1, 16'h1111);
        vectors++;
        if (I_addr !== 16'h4000 || got_v !== exp_v) begin
            miscompares++;
            $display("FAIL redir_target addr=%h exp 4000 got=%h exp=%h", I_addr, got_v, exp_v);
        end
        tick();
    endtask

    task automatic test_redirect_stall_hold();
        apply(1, 0, 16'h0, 1, 16'h2222);
        tick();
        apply(1, 1, 16'h1001, 0, 16'h0);
        vectors++;
        if ({if_id_load, inst_valid} !== 2'b10 || got_v !== exp_v) begin
            miscompares++;
            $display("FAIL redir_hold ld=%b v=%b got=%h exp=%h", if_id_load, inst_valid, got_v, exp_v);
        end
        tick();
        apply(0, 0, 16'h0, 1, 16'h3333);
        vectors++;
        if (I_addr !== 16'h1000 || got_v !== exp_v) begin
            miscompares++;
            $display("FAIL redir_hold_next addr=%h exp 1000 got=%h exp=%h", I_addr, got_v, exp_v);
        end
        tick();
    endtask

    task automatic test_wrap_reset();
        apply(0, 1, 16'hFFFE, 1, 16'h0);
        tick();
        apply(0, 0, 16'h0, 1, 16'h6060);
        vectors++;
        if (PC_out !== 16'h0000 || I_addr !== 16'hFFFE || got_v !== exp_v) begin
            miscompares++;
            $display("FAIL wrap pc_out=%h addr=%h exp 0000 FFFE", PC_out, I_addr);
        end
        tick();
        apply(0, 1, 16'h0100, 0, 16'h0);
        vectors++;
        if (I_addr !== 16'h0000 || got_v !== exp_v) begin
            miscompares++;
            $display("FAIL wrap_next addr=%h exp 0000 got=%h exp=%h", I_addr, got_v, exp_v);
        end
        tick();
        apply(0, 0, 16'h0, 0, 16'h0);
        rst_n = 1'b0;
        #1;
        model_reset();
        vectors++;
        if (I_read !== 1'b0 || got_v !== 51'd0) begin
            miscompares++;
            $display("FAIL midreset rd=%b got=%h exp=0", I_read, got_v);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        apply(0, 0, 16'h0, 1, 16'h0F0F);
        vectors++;
        if ({I_read, I_addr} !== {1'b1, 16'h0000} || got_v !== exp_v) begin
            miscompares++;
            $display("FAIL after_reset rd=%b addr=%h exp 1 0000", I_read, I_addr);
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            apply($urandom_range(3, 0) == 0, $urandom_range(9, 0) == 0,
                  16'($urandom), $urandom_range(9, 0) < 6, 16'($urandom));
            vectors++;
            if (got_v !== exp_v) begin
                miscompares++;
                $display("FAIL random%0d st=%b rd=%b rsp=%b got=%h exp=%h",
                         i, stall, redirect, I_resp, got_v, exp_v);
            end
            tick();
        end
    endtask

    initial begin
        stall = 0; redirect = 0; redirect_pc = 0; I_resp = 0; I_rdata = 0; rst_n = 0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_wait();
        test_stall();
        test_redirect_drain();
        test_redirect_stall_hold();
        test_wrap_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
